// File: rtl/pulse_transmitter_symbol_sequencer.sv
// Symbol sequencer for the pulse transmitter.
// Buffers {level, duration} symbols in a small FIFO and feeds them to the
// repeating countdown timer. Duration and prescaler are loaded one cycle
// before timer enable. The pin level changes on each end-of-symbol pulse.
// Completion is flagged once the FIFO has run dry.
//
// Write handshake: a symbol is accepted on any rising edge where
// wr_valid && wr_ready. wr_ready is combinational !full and does not depend
// on wr_valid. A write presented while full is dropped, not held.
module pulse_transmitter_symbol_sequencer #(
    parameter int PRESCALER_WIDTH = 16,
    parameter int TIMER_WIDTH     = 8,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               sys_rst,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               idle_level,
    input  logic [$clog2(PRESCALER_WIDTH)-1:0] cfg_prescaler,
    input  logic                               wr_valid,
    input  logic [TIMER_WIDTH:0]               wr_data,
    output logic                               wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               timer_en,
    output logic [$clog2(PRESCALER_WIDTH)-1:0] timer_prescaler,
    output logic [TIMER_WIDTH-1:0]             timer_duration,
    input  logic                               timer_request_data,
    input  logic                               timer_pulse,
    output logic                               tx_out,
    output logic                               busy,
    output logic                               done
);

    localparam int PS_W  = $clog2(PRESCALER_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [TIMER_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic                   head_level;
    logic [TIMER_WIDTH-1:0] head_duration;

    // Sequencer state
    state_t                 state_q;
    state_t                 state_d;
    logic                   cur_level_q;
    logic                   next_level_q;
    logic                   next_valid_q;
    logic                   last_q;
    logic                   finish;

    // Next values of the registered outputs and internal flags
    logic                   timer_en_d;
    logic [PS_W-1:0]        timer_prescaler_d;
    logic [TIMER_WIDTH-1:0] timer_duration_d;
    logic                   tx_out_d;
    logic                   done_d;
    logic                   cur_level_d;
    logic                   next_level_d;
    logic                   next_valid_d;
    logic                   last_d;

    assign full          = (count == LVL_W'(FIFO_DEPTH));
    assign empty         = (count == '0);
    assign wr_ready      = !full;
    assign fifo_level    = count;
    assign push          = wr_valid && !full;
    assign head_level    = mem[rd_ptr][TIMER_WIDTH];
    assign head_duration = mem[rd_ptr][TIMER_WIDTH-1:0];
    assign busy          = (state_q != S_IDLE);
    // Normal end: last symbol's pulse with nothing pending and no more data
    assign finish        = (state_q == S_RUN) && timer_pulse && !next_valid_q && last_q;

    // FIFO payload storage, written on accepted symbols
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop overrides everything
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && !empty) state_d = S_PRIME;
                S_PRIME: state_d = S_RUN;
                S_RUN:   if (finish) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output and datapath next values, including the FIFO pop decision
    always_comb begin
        pop               = 1'b0;
        timer_en_d        = timer_en;
        timer_prescaler_d = timer_prescaler;
        timer_duration_d  = timer_duration;
        tx_out_d          = tx_out;
        done_d            = 1'b0;
        cur_level_d       = cur_level_q;
        next_level_d      = next_level_q;
        next_valid_d      = next_valid_q;
        last_d            = last_q;
        if (stop) begin
            timer_en_d   = 1'b0;
            tx_out_d     = idle_level;
            next_valid_d = 1'b0;
            last_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    timer_en_d = 1'b0;
                    tx_out_d   = idle_level;
                    if (start && !empty) begin
                        pop               = 1'b1;
                        timer_duration_d  = head_duration;
                        cur_level_d       = head_level;
                        timer_prescaler_d = cfg_prescaler;
                    end
                end
                S_PRIME: begin
                    timer_en_d = 1'b1;
                    tx_out_d   = cur_level_q;
                end
                S_RUN: begin
                    if (finish) begin
                        timer_en_d = 1'b0;
                        tx_out_d   = idle_level;
                        done_d     = 1'b1;
                        last_d     = 1'b0;
                    end else begin
                        // Pulse consumes the pending level before a same-cycle request reloads it
                        if (timer_pulse && next_valid_q) begin
                            tx_out_d     = next_level_q;
                            next_valid_d = 1'b0;
                        end
                        if (timer_request_data) begin
                            if (!empty) begin
                                pop              = 1'b1;
                                timer_duration_d = head_duration;
                                next_level_d     = head_level;
                                next_valid_d     = 1'b1;
                            end else begin
                                last_d = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    timer_en_d = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs and sequencing flags
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer_en        <= 1'b0;
            timer_prescaler <= '0;
            timer_duration  <= '0;
            tx_out          <= 1'b0;
            done            <= 1'b0;
            cur_level_q     <= 1'b0;
            next_level_q    <= 1'b0;
            next_valid_q    <= 1'b0;
            last_q          <= 1'b0;
        end else begin
            timer_en        <= timer_en_d;
            timer_prescaler <= timer_prescaler_d;
            timer_duration  <= timer_duration_d;
            tx_out          <= tx_out_d;
            done            <= done_d;
            cur_level_q     <= cur_level_d;
            next_level_q    <= next_level_d;
            next_valid_q    <= next_valid_d;
            last_q          <= last_d;
        end
    end

endmodule

// File: tb/tb_pulse_transmitter_symbol_sequencer.sv
// Bench for pulse_transmitter_symbol_sequencer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_pulse_transmitter_symbol_sequencer;

    localparam int PW = 16;
    localparam int TW = 8;
    localparam int FD = 4;
    localparam int SW = $clog2(PW);
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          idle_level = 1'b1;
    logic [SW-1:0] cfg_prescaler = '0;
    logic          wr_valid = 1'b0;
    logic [TW:0]   wr_data = '0;
    logic          wr_ready;
    logic [LW-1:0] fifo_level;
    logic          timer_en;
    logic [SW-1:0] timer_prescaler;
    logic [TW-1:0] timer_duration;
    logic          timer_request_data = 1'b0;
    logic          timer_pulse = 1'b0;
    logic          tx_out;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    pulse_transmitter_symbol_sequencer #(
        .PRESCALER_WIDTH(PW),
        .TIMER_WIDTH    (TW),
        .FIFO_DEPTH     (FD)
    ) dut (
        .clk               (clk),
        .sys_rst           (sys_rst),
        .start             (start),
        .stop              (stop),
        .idle_level        (idle_level),
        .cfg_prescaler     (cfg_prescaler),
        .wr_valid          (wr_valid),
        .wr_data           (wr_data),
        .wr_ready          (wr_ready),
        .fifo_level        (fifo_level),
        .timer_en          (timer_en),
        .timer_prescaler   (timer_prescaler),
        .timer_duration    (timer_duration),
        .timer_request_data(timer_request_data),
        .timer_pulse       (timer_pulse),
        .tx_out            (tx_out),
        .busy              (busy),
        .done              (done)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Symbols held as a plain queue; phase 0 = idle, 1 = priming, 2 = running.
    logic [TW:0]   m_fifo[$];
    int            m_phase;
    logic          m_en, m_tx, m_done, m_cur, m_next_lvl, m_has_next, m_last;
    logic [TW-1:0] m_dur;
    logic [SW-1:0] m_ps;
    logic [TW:0]   m_head;
    int            m_size;
    bit            m_take;

    always @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_fifo.delete();
            m_phase = 0; m_en = 0; m_tx = 0; m_done = 0; m_cur = 0;
            m_next_lvl = 0; m_has_next = 0; m_last = 0; m_dur = '0; m_ps = '0;
        end else begin
            m_size = m_fifo.size();
            m_head = (m_size > 0) ? m_fifo[0] : '0;
            m_take = 1'b0;
            m_done = 1'b0;
            if (stop) begin
                m_phase = 0; m_en = 0; m_tx = idle_level; m_has_next = 0; m_last = 0;
            end else if (m_phase == 0) begin
                m_en = 0;
                m_tx = idle_level;
                if (start && m_size > 0) begin
                    m_take = 1'b1;
                    m_dur = m_head[TW-1:0]; m_cur = m_head[TW]; m_ps = cfg_prescaler;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_en = 1; m_tx = m_cur; m_phase = 2;
            end else begin
                if (timer_pulse && !m_has_next && m_last) begin
                    m_en = 0; m_tx = idle_level; m_done = 1; m_last = 0; m_phase = 0;
                end else begin
                    if (timer_pulse && m_has_next) begin
                        m_tx = m_next_lvl; m_has_next = 0;
                    end
                    if (timer_request_data) begin
                        if (m_size > 0) begin
                            m_take = 1'b1;
                            m_dur = m_head[TW-1:0]; m_next_lvl = m_head[TW]; m_has_next = 1;
                        end else begin
                            m_last = 1;
                        end
                    end
                end
            end
            if (m_take) void'(m_fifo.pop_front());
            if (wr_valid && m_size < FD) m_fifo.push_back(wr_data);
        end
    end

    // Scoreboard: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("timer_en",   32'(timer_en),        32'(m_en));
            check("duration",   32'(timer_duration),  32'(m_dur));
            check("prescaler",  32'(timer_prescaler), 32'(m_ps));
            check("tx_out",     32'(tx_out),          32'(m_tx));
            check("done",       32'(done),            32'(m_done));
            check("busy",       32'(busy),            32'(m_phase != 0));
            check("fifo_level", 32'(fifo_level),      32'(m_fifo.size()));
            check("wr_ready",   32'(wr_ready),        32'(m_fifo.size() < FD));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_sym(input logic lvl, input logic [TW-1:0] dur);
        wr_valid = 1'b1;
        wr_data  = {lvl, dur};
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_inputs(input bit req, input bit pls);
        timer_request_data = req;
        timer_pulse        = pls;
        tick();
        timer_request_data = 1'b0;
        timer_pulse        = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 sys_rst = 1'b1;
        tick();
        chk_en = 1'b1;
        check("rst_en",  32'(timer_en), 32'd0);
        check("rst_tx",  32'(tx_out), 32'd0);
        check("rst_lvl", 32'(fifo_level), 32'd0);
        tick();
        sys_rst = 1'b0;
        tick();

        // Basic two-symbol transmission, idle level high
        write_sym(1'b1, 8'd3);
        write_sym(1'b0, 8'd5);
        check("two_written", 32'(fifo_level), 32'd2);
        cfg_prescaler = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("prime_dur", 32'(timer_duration), 32'd3);
        check("prime_en",  32'(timer_en), 32'd0);
        check("prime_busy", 32'(busy), 32'd1);
        tick();
        check("run_en", 32'(timer_en), 32'd1);
        check("run_tx", 32'(tx_out), 32'd1);
        pulse_inputs(1'b1, 1'b0);
        check("req_dur", 32'(timer_duration), 32'd5);
        check("req_lvl", 32'(fifo_level), 32'd0);
        pulse_inputs(1'b0, 1'b1);
        check("pulse1_tx", 32'(tx_out), 32'd0);
        pulse_inputs(1'b1, 1'b0);
        pulse_inputs(1'b0, 1'b1);
        check("end_tx",   32'(tx_out), 32'd1);
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_en",   32'(timer_en), 32'd0);
        tick();
        check("done_1cyc", 32'(done), 32'd0);

        // Overfill: five writes into four entries
        for (int i = 0; i < 5; i++) begin
            write_sym(i[0], 8'(10 + i));
            if (i == 3) check("full_ready", 32'(wr_ready), 32'd0);
        end
        check("full_lvl", 32'(fifo_level), 32'd4);

        // Same-cycle request and pulse with a pending symbol
        cfg_prescaler = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s0_dur", 32'(timer_duration), 32'd10);
        check("s0_ps",  32'(timer_prescaler), 32'd9);
        tick();
        check("s0_tx", 32'(tx_out), 32'd0);
        pulse_inputs(1'b1, 1'b0);
        check("s1_dur", 32'(timer_duration), 32'd11);
        pulse_inputs(1'b1, 1'b1);
        check("both_tx",  32'(tx_out), 32'd1);
        check("both_dur", 32'(timer_duration), 32'd12);
        check("both_lvl", 32'(fifo_level), 32'd1);
        pulse_inputs(1'b0, 1'b1);
        check("s2_tx", 32'(tx_out), 32'd0);

        // Stop with two symbols queued, then resume from the queued head
        write_sym(1'b1, 8'd20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_en",   32'(timer_en), 32'd0);
        check("stop_tx",   32'(tx_out), 32'd1);
        check("stop_done", 32'(done), 32'd0);
        check("stop_lvl",  32'(fifo_level), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("resume_dur", 32'(timer_duration), 32'd13);
        tick();
        tick();
        check("resume_en", 32'(timer_en), 32'd1);

        // Asynchronous reset between clock edges
        #2 sys_rst = 1'b1;
        #1;
        check("arst_en", 32'(timer_en), 32'd0);
        check("arst_tx", 32'(tx_out), 32'd0);
        tick();
        sys_rst = 1'b0;
        check("arst_lvl", 32'(fifo_level), 32'd0);

        // Start with empty FIFO is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_en",   32'(timer_en), 32'd0);
        tick();
        check("empty_done", 32'(done), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            wr_valid           = ($urandom_range(0, 99) < 40);
            wr_data            = 9'($urandom);
            start              = ($urandom_range(0, 99) < 10);
            stop               = ($urandom_range(0, 99) < 2);
            timer_request_data = ($urandom_range(0, 99) < 25);
            timer_pulse        = ($urandom_range(0, 99) < 25);
            cfg_prescaler      = 4'($urandom);
            if ($urandom_range(0, 99) < 5) idle_level = ~idle_level;
            tick();
        end
        wr_valid = 1'b0; start = 1'b0; stop = 1'b0;
        timer_request_data = 1'b0; timer_pulse = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
